// File: rtl/debug_monitor_if.sv
// Signal bundle between the halt monitor, the processor's wait/debug ports and the host dump stream.
// The monitor uses the master view; the processor/host side uses the slave view.
interface debug_monitor_if #(
  parameter int WORD_SIZE = 18
);
  logic                 wait_for_continue;
  logic                 wait_continue_execution;
  logic                 debug_get_param;
  logic [3:0]           debug_reg_addr;
  logic [WORD_SIZE-1:0] debug_data_out;
  logic                 dump_valid;
  logic [WORD_SIZE-1:0] dump_data;
  logic [3:0]           dump_index;
  logic                 dump_ready;
  logic                 host_continue;
  logic                 halted;
  logic [7:0]           halt_count;

  modport master (
    input  wait_for_continue,
    input  debug_data_out,
    input  dump_ready,
    input  host_continue,
    output wait_continue_execution,
    output debug_get_param,
    output debug_reg_addr,
    output dump_valid,
    output dump_data,
    output dump_index,
    output halted,
    output halt_count
  );

  modport slave (
    output wait_for_continue,
    output debug_data_out,
    output dump_ready,
    output host_continue,
    input  wait_continue_execution,
    input  debug_get_param,
    input  debug_reg_addr,
    input  dump_valid,
    input  dump_data,
    input  dump_index,
    input  halted,
    input  halt_count
  );
endinterface

// File: rtl/debug_monitor.sv
// Halt monitor: on a processor `wait`, dumps r0..r7 and ip as a valid/ready stream,
// then holds the processor until the host asks to continue and releases it with one pulse.
module debug_monitor #(
  parameter int WORD_SIZE = 18,
  parameter int REG_COUNT = 8
) (
  input logic             clock,
  input logic             reset,
  debug_monitor_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SEND,
    WAIT_HOST,
    RELEASE,
    WAIT_DROP
  } state_t;

  state_t               r_state;
  logic [3:0]           r_k;
  logic                 r_wce;
  logic                 r_get_param;
  logic [3:0]           r_reg_addr;
  logic                 r_dump_valid;
  logic [WORD_SIZE-1:0] r_dump_data;
  logic [3:0]           r_dump_index;
  logic                 r_halted;
  logic [7:0]           r_halt_count;

  logic w_last;
  logic w_abort;

  assign w_last  = (r_k == 4'(REG_COUNT));
  // A dropped halt level while dumping or waiting means the processor was reset underneath us.
  assign w_abort = !bus.wait_for_continue &&
                   ((r_state == SETUP) || (r_state == SEND) || (r_state == WAIT_HOST));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_k          <= 4'd0;
      r_wce        <= 1'b0;
      r_get_param  <= 1'b0;
      r_reg_addr   <= 4'd0;
      r_dump_valid <= 1'b0;
      r_dump_data  <= '0;
      r_dump_index <= 4'd0;
      r_halted     <= 1'b0;
      r_halt_count <= 8'd0;
    end else begin
      r_wce <= 1'b0;
      if (w_abort) begin
        r_state      <= IDLE;
        r_k          <= 4'd0;
        r_dump_valid <= 1'b0;
        r_get_param  <= 1'b0;
        r_halted     <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (bus.wait_for_continue) begin
              r_state     <= SETUP;
              r_k         <= 4'd0;
              r_halted    <= 1'b1;
              r_get_param <= 1'b1;
              r_reg_addr  <= 4'd0;
              if (r_halt_count != 8'hFF) begin
                r_halt_count <= r_halt_count + 8'd1;
              end
            end
          end
          SETUP: begin
            r_dump_data  <= bus.debug_data_out;
            r_dump_index <= r_k;
            r_dump_valid <= 1'b1;
            r_state      <= SEND;
          end
          SEND: begin
            if (bus.dump_ready) begin
              r_dump_valid <= 1'b0;
              if (w_last) begin
                r_state     <= WAIT_HOST;
                r_get_param <= 1'b0;
              end else begin
                r_k        <= r_k + 4'd1;
                r_reg_addr <= r_k + 4'd1;
                r_state    <= SETUP;
              end
            end
          end
          WAIT_HOST: begin
            // The release pulse is registered on entry so it lines up with the RELEASE cycle.
            if (bus.host_continue) begin
              r_state <= RELEASE;
              r_wce   <= 1'b1;
            end
          end
          RELEASE: begin
            r_halted <= 1'b0;
            r_state  <= WAIT_DROP;
          end
          WAIT_DROP: begin
            if (!bus.wait_for_continue) begin
              r_state <= IDLE;
            end
          end
          default: begin
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.wait_continue_execution = r_wce;
  assign bus.debug_get_param         = r_get_param;
  assign bus.debug_reg_addr          = r_reg_addr;
  assign bus.dump_valid              = r_dump_valid;
  assign bus.dump_data               = r_dump_data;
  assign bus.dump_index              = r_dump_index;
  assign bus.halted                  = r_halted;
  assign bus.halt_count              = r_halt_count;

endmodule

// File: tb/tb_debug_monitor.sv
// Bench for debug_monitor: a register-file processor model, a word scoreboard fed at halt time,
// a cycle table for the first dump and hand-written sequences for backpressure, abort, reset and saturation.
module tb_debug_monitor;

  localparam int WORD_SIZE = 18;
  localparam int REG_COUNT = 8;

  typedef struct {
    logic [WORD_SIZE-1:0] data;
    logic [3:0]           index;
  } word_t;

  typedef struct {
    logic       ready;
    logic       hostContinue;
    logic       expValid;
    logic       expGetParam;
    logic [3:0] expAddr;
    logic       expHalted;
    logic       expWce;
  } vec_t;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  debug_monitor_if #(.WORD_SIZE(WORD_SIZE)) bus ();

  debug_monitor #(
    .WORD_SIZE(WORD_SIZE),
    .REG_COUNT(REG_COUNT)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  logic [WORD_SIZE-1:0] procRegs [0:15];
  assign bus.debug_data_out = bus.debug_get_param ? procRegs[bus.debug_reg_addr] : '0;

  word_t expQ[$];
  int    checks    = 0;
  int    errors    = 0;
  int    wcePulses = 0;
  vec_t  dumpTbl[19];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual 0x%0h required 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    bus.dump_ready    = v.ready;
    bus.host_continue = v.hostContinue;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pushDump(input int count);
    for (int i = 0; i < count; i++) begin
      expQ.push_back(word_t'{data: procRegs[i], index: 4'(i)});
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".wce"},       32'(bus.wait_continue_execution), 32'd0);
    checkOutput({tag, ".getParam"},  32'(bus.debug_get_param),         32'd0);
    checkOutput({tag, ".regAddr"},   32'(bus.debug_reg_addr),          32'd0);
    checkOutput({tag, ".valid"},     32'(bus.dump_valid),              32'd0);
    checkOutput({tag, ".data"},      32'(bus.dump_data),               32'd0);
    checkOutput({tag, ".index"},     32'(bus.dump_index),              32'd0);
    checkOutput({tag, ".halted"},    32'(bus.halted),                  32'd0);
    checkOutput({tag, ".haltCount"}, 32'(bus.halt_count),              32'd0);
  endtask

  task automatic waitHostState(input string tag);
    int n = 0;
    while (bus.debug_get_param && n < 40) begin
      tick();
      n++;
    end
    if (bus.debug_get_param) begin
      checkOutput({tag, ".timeout"}, 32'd1, 32'd0);
    end
    checkOutput({tag, ".queueDrained"}, 32'(expQ.size()), 32'd0);
  endtask

  task automatic releaseHalt();
    bus.host_continue = 1'b1;
    tick();
    bus.host_continue     = 1'b0;
    bus.wait_for_continue = 1'b0;
    tick();
    tick();
  endtask

  // Every accepted word is compared against the next expected word; extra words count as failures.
  always @(negedge clock) begin : monitor
    word_t w;
    if (reset && bus.dump_valid && bus.dump_ready) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL scoreboard: actual word idx %0d data 0x%0h required no word",
                 bus.dump_index, bus.dump_data);
      end else begin
        w = expQ.pop_front();
        checkOutput("sb.index", 32'(bus.dump_index), 32'(w.index));
        checkOutput("sb.data",  32'(bus.dump_data),  32'(w.data));
      end
    end
    if (reset && bus.wait_continue_execution) begin
      wcePulses++;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: actual still running required finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int c = 0; c < 19; c++) begin
      dumpTbl[c].ready        = 1'b1;
      dumpTbl[c].hostContinue = (c == 5) || (c == 18);
      dumpTbl[c].expValid     = (c % 2) == 1;
      dumpTbl[c].expGetParam  = (c != 18);
      dumpTbl[c].expAddr      = (c == 18) ? 4'd8 : ((c % 2) == 1 ? 4'((c - 1) / 2) : 4'(c / 2));
      dumpTbl[c].expHalted    = 1'b1;
      dumpTbl[c].expWce       = 1'b0;
    end
    for (int i = 0; i < 16; i++) procRegs[i] = '0;

    reset                 = 1'b0;
    bus.wait_for_continue = 1'b0;
    bus.dump_ready        = 1'b0;
    bus.host_continue     = 1'b0;

    repeat (3) tick();
    checkAllZero("inReset");
    reset = 1'b1;
    tick();
    tick();
    checkAllZero("afterReset");

    // First dump, cycle by cycle from the halt-detecting edge E.
    for (int i = 0; i < REG_COUNT; i++) procRegs[i] = 18'(i + 1);
    procRegs[REG_COUNT] = 18'h0002A;
    pushDump(9);
    bus.wait_for_continue = 1'b1;
    for (int c = 0; c < 19; c++) begin
      applyStimulus(dumpTbl[c]);
      tick();
      checkOutput($sformatf("dump1[%0d].valid", c),    32'(bus.dump_valid),              32'(dumpTbl[c].expValid));
      checkOutput($sformatf("dump1[%0d].getParam", c), 32'(bus.debug_get_param),         32'(dumpTbl[c].expGetParam));
      checkOutput($sformatf("dump1[%0d].regAddr", c),  32'(bus.debug_reg_addr),          32'(dumpTbl[c].expAddr));
      checkOutput($sformatf("dump1[%0d].halted", c),   32'(bus.halted),                  32'(dumpTbl[c].expHalted));
      checkOutput($sformatf("dump1[%0d].wce", c),      32'(bus.wait_continue_execution), 32'(dumpTbl[c].expWce));
      if (dumpTbl[c].expValid) begin
        checkOutput($sformatf("dump1[%0d].index", c), 32'(bus.dump_index), 32'(dumpTbl[c].expAddr));
      end
      if (c == 0) checkOutput("dump1.haltCount", 32'(bus.halt_count), 32'd1);
    end
    checkOutput("dump1.queueDrained", 32'(expQ.size()), 32'd0);

    bus.host_continue = 1'b0;
    repeat (2) begin
      tick();
      checkOutput("waitHost.wce",    32'(bus.wait_continue_execution), 32'd0);
      checkOutput("waitHost.halted", 32'(bus.halted),                  32'd1);
    end
    bus.host_continue = 1'b1;
    tick();
    checkOutput("release.wce",    32'(bus.wait_continue_execution), 32'd1);
    checkOutput("release.halted", 32'(bus.halted),                  32'd1);
    bus.host_continue = 1'b0;
    tick();
    checkOutput("afterRelease.wce",    32'(bus.wait_continue_execution), 32'd0);
    checkOutput("afterRelease.halted", 32'(bus.halted),                  32'd0);
    repeat (4) begin
      tick();
      checkOutput("holdHigh.getParam", 32'(bus.debug_get_param), 32'd0);
      checkOutput("holdHigh.valid",    32'(bus.dump_valid),      32'd0);
      checkOutput("holdHigh.halted",   32'(bus.halted),          32'd0);
    end
    checkOutput("holdHigh.wcePulses", 32'(wcePulses),      32'd1);
    checkOutput("holdHigh.haltCount", 32'(bus.halt_count), 32'd1);
    bus.wait_for_continue = 1'b0;
    tick();
    tick();

    // Second dump with backpressure on word 3.
    procRegs[3] = 18'h3FFFF;
    pushDump(9);
    bus.wait_for_continue = 1'b1;
    bus.dump_ready        = 1'b1;
    tick();
    checkOutput("dump2.haltCount", 32'(bus.halt_count), 32'd2);
    repeat (6) tick();
    bus.dump_ready = 1'b0;
    tick();
    for (int i = 0; i < 6; i++) begin
      checkOutput($sformatf("stall[%0d].valid", i), 32'(bus.dump_valid), 32'd1);
      checkOutput($sformatf("stall[%0d].data", i),  32'(bus.dump_data),  32'h3FFFF);
      checkOutput($sformatf("stall[%0d].index", i), 32'(bus.dump_index), 32'd3);
      if (i < 5) tick();
    end
    bus.dump_ready = 1'b1;
    waitHostState("dump2");
    releaseHalt();
    checkOutput("dump2.wcePulses", 32'(wcePulses), 32'd2);

    // Abort after word 2 has been accepted.
    pushDump(3);
    bus.wait_for_continue = 1'b1;
    tick();
    repeat (6) tick();
    bus.wait_for_continue = 1'b0;
    tick();
    checkOutput("abort.valid",    32'(bus.dump_valid),              32'd0);
    checkOutput("abort.getParam", 32'(bus.debug_get_param),         32'd0);
    checkOutput("abort.halted",   32'(bus.halted),                  32'd0);
    checkOutput("abort.wce",      32'(bus.wait_continue_execution), 32'd0);
    checkOutput("abort.queueDrained", 32'(expQ.size()), 32'd0);
    repeat (3) tick();
    checkOutput("abort.wcePulses", 32'(wcePulses),           32'd2);
    checkOutput("abort.idle",      32'(bus.debug_get_param), 32'd0);

    // Abort in the very first SETUP cycle; a fresh halt is detected from IDLE.
    bus.wait_for_continue = 1'b1;
    tick();
    checkOutput("abort2.getParam",  32'(bus.debug_get_param), 32'd1);
    checkOutput("abort2.haltCount", 32'(bus.halt_count),      32'd4);
    bus.wait_for_continue = 1'b0;
    tick();
    checkOutput("abort2.getParamOff", 32'(bus.debug_get_param), 32'd0);
    checkOutput("abort2.valid",       32'(bus.dump_valid),      32'd0);
    checkOutput("abort2.halted",      32'(bus.halted),          32'd0);
    tick();

    // Asynchronous reset while a word is held in SEND.
    bus.wait_for_continue = 1'b1;
    bus.dump_ready        = 1'b0;
    tick();
    tick();
    checkOutput("midSend.valid", 32'(bus.dump_valid), 32'd1);
    #1 reset = 1'b0;
    #1;
    checkOutput("asyncReset.valid",     32'(bus.dump_valid),      32'd0);
    checkOutput("asyncReset.getParam",  32'(bus.debug_get_param), 32'd0);
    checkOutput("asyncReset.halted",    32'(bus.halted),          32'd0);
    checkOutput("asyncReset.haltCount", 32'(bus.halt_count),      32'd0);
    bus.wait_for_continue = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    checkAllZero("afterAsyncReset");

    // Saturation of the halt counter.
    for (int h = 1; h <= 300; h++) begin
      pushDump(9);
      bus.wait_for_continue = 1'b1;
      bus.dump_ready        = 1'b1;
      tick();
      if (h == 254) checkOutput("sat.count254", 32'(bus.halt_count), 32'd254);
      waitHostState($sformatf("sat[%0d]", h));
      releaseHalt();
    end
    checkOutput("sat.count255", 32'(bus.halt_count), 32'd255);
    checkOutput("sat.halted",   32'(bus.halted),     32'd0);
    checkOutput("sat.wcePulses", 32'(wcePulses),     32'd302);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
